// File: rtl/usart_rx.sv
// usart_rx: 8N1 UART receiver with a held data register and a ready/ack handshake.
// One bit period is prescaler+1 clocks, and each bit is sampled near mid-bit.
module usart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PRESC_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic               rx_pin,
    input  logic               read_ack,
    output logic [7:0]         data,
    output logic               rx_ready,
    output logic               overrun,
    output logic               framing_error,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [PRESC_W-1:0] ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   w_presc_nxt;
    logic [PRESC_W-1:0]   r_timer;
    logic [PRESC_W-1:0]   w_timer_nxt;
    logic [2:0]           r_bitcnt;
    logic [2:0]           w_bitcnt_nxt;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_nxt;
    logic [7:0]           r_data;
    logic [7:0]           w_data_nxt;
    logic                 r_ready;
    logic                 w_ready_nxt;
    logic                 r_overrun;
    logic                 w_overrun_nxt;
    logic                 r_ferr;
    logic                 w_ferr_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 w_rxs;
    logic                 w_tick;

    assign w_rxs  = r_sync[SYNC_STAGES-1];
    // START waits half a bit; every later phase waits a full bit.
    assign w_tick = (r_state == S_START) ? (r_timer == (r_presc >> 1))
                                         : (r_timer == r_presc);

    assign data          = r_data;
    assign rx_ready      = r_ready;
    assign overrun       = r_overrun;
    assign framing_error = r_ferr;
    assign busy          = r_busy;

    // Synchronise the asynchronous serial line; resets to the idle (high) level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_pin};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_timer   <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_timer   <= w_timer_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_ready   <= w_ready_nxt;
            r_overrun <= w_overrun_nxt;
            r_ferr    <= w_ferr_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state logic: frame sequencing, sampling and the consumer handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_timer_nxt   = r_timer + ONE;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_ready_nxt   = r_ready;
        w_overrun_nxt = r_overrun;
        w_ferr_nxt    = 1'b0;
        w_busy_nxt    = r_busy;

        // An ack consumes the byte; a same-cycle completion below re-arms ready.
        if (read_ack) begin
            w_ready_nxt   = 1'b0;
            w_overrun_nxt = 1'b0;
        end

        unique case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (!w_rxs) begin
                    w_presc_nxt  = prescaler;
                    w_bitcnt_nxt = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_timer_nxt = '0;
                    if (w_rxs) begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_timer_nxt           = '0;
                    w_shift_nxt[r_bitcnt] = w_rxs;
                    w_bitcnt_nxt          = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_timer_nxt = '0;
                    if (w_rxs) begin
                        if (!r_ready || read_ack) begin
                            w_data_nxt  = r_shift;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low must not be mistaken for a new start bit.
                w_timer_nxt = '0;
                if (w_rxs) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
UART receiver that sits on the far end of the serial link driven by the team's 8N1 transmitter. It deserialises `rx_pin` into bytes using the same 16-bit prescaler convention: one bit period is prescaler+1 clocks. Each received byte is presented on a held data register with a ready/acknowledge handshake toward the consuming logic. Framing errors and overruns are reported.

Parameters:
- SYNC_STAGES, 2, number of flops in the `rx_pin` synchroniser (minimum 2).
- PRESC_W, 16, width of the prescaler input and the bit-timing counter.

Ports:
- clock  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- prescaler  input  PRESC_W  bit period minus 1, in clocks; captured at start-bit detect and held for the frame; legal values are 3 or greater.
- rx_pin  input  1  serial line; idles high.
- read_ack  input  1  consumer pulse that clears `rx_ready` and `overrun`.
- data  output  8  last good byte; bit 0 = first data bit received (LSB first).
- rx_ready  output  1  high while `data` holds an unread byte.
- overrun  output  1  sticky; a good byte completed while `rx_ready` was already 1.
- framing_error  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset: all synchroniser flops = 1, state = IDLE, counters = 0, `data` = 0x00, and `rx_ready`, `overrun`, `framing_error`, `busy` = 0. Reset applies immediately and asynchronously. Asserting it mid-frame discards the partial byte.
- `rxs` is the synchronised `rx_pin`; all decisions use `rxs`.
- IDLE: on `rxs` = 0, capture prescaler into `presc_q`, clear bit counter, set `busy` = 1, go to START. `half` = `presc_q` >> 1.
- START: count `half` + 1 clocks, then sample `rxs`.
  - If `rxs` = 1, it was a glitch: go to IDLE, `busy` = 0, nothing else changes.
  - If `rxs` = 0, go to DATA with the timer cleared.
- DATA: every `presc_q` + 1 clocks, sample `rxs` into shift register bit [`bitcnt`], then increment `bitcnt`. After the 8th sample go to STOP.
- STOP: after `presc_q` + 1 clocks, sample `rxs`.
  - If 1 (good frame):
    - If `rx_ready` = 0 or `read_ack` = 1 this cycle: load `data` from the shift register and set `rx_ready` = 1.
    - Otherwise keep the old `data`, discard the new byte, and set `overrun` = 1.
    - Then go to IDLE with `busy` = 0.
  - If 0: pulse `framing_error` for 1 cycle, leave `data`/`rx_ready` untouched, go to BREAK.
- BREAK: hold `busy` = 1 until `rxs` = 1, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- Sampling point is mid-bit. With prescaler P, the stop sample lands (P+1)·9 + (P>>1) + 1 clocks after the start edge is seen on `rxs`, plus SYNC_STAGES of input latency.
- `rx_ready` / `data` / `overrun` update on the clock edge after the stop sample.
- `read_ack` with `rx_ready` = 1 and no completion in the same cycle: `rx_ready` = 0 and `overrun` = 0 next cycle.
- `read_ack` while `rx_ready` = 0: `rx_ready` unchanged, `overrun` cleared.
- Simultaneous `read_ack` and good-frame completion: new byte loaded, `rx_ready` stays 1, `overrun` not set (cleared if it was set).
- Timer is PRESC_W bits wide and compares for equality against `presc_q`, so it never wraps within a frame. Prescaler changes mid-frame have no effect until the next start.
- `framing_error` and good completion are mutually exclusive within a frame.

Test Plan:
1. Reset, prescaler = 9, drive 8N1 0xA5 at 10 clocks/bit -> `data` = 0xA5, `rx_ready` = 1, `busy` returns to 0, `framing_error` never asserted.
2. `rx_pin` low for 3 clocks then high, prescaler = 9 -> `busy` pulses, returns to IDLE at the START sample, `rx_ready` stays 0, and a following 0x3C frame is received correctly.
3. 0x55 with stop bit driven 0, line then held low 40 clocks -> `framing_error` is a single 1-cycle pulse, `rx_ready` stays 0, `busy` stays 1 until the line goes high, and the next 0x81 frame is received.
4. Send 0x11 without ack, then 0x22 -> `data` = 0x11, `rx_ready` = 1, `overrun` = 1. Then pulse `read_ack` -> `rx_ready` = 0 and `overrun` = 0.
5. Send 0x11 unacked, then assert `read_ack` exactly on the cycle 0x22 completes -> `data` = 0x22, `rx_ready` = 1, `overrun` = 0.
6. Assert reset during bit 4 of 0xF0, release it, then send 0x0F at prescaler = 3 -> all outputs 0 during reset, then `data` = 0x0F with no error.
